// File: rtl/keystream_cipher.sv
// keystream_cipher
//  Downstream stage for three external LFSRs (5/7/9-bit). Latches a 21-bit key
//  that seeds the LFSRs, combines their output bits into one keystream bit per
//  clock, packs 8 bits per byte into a small FIFO and XORs a valid/ready byte
//  stream with it. Encryption and decryption are the same operation.
//
//  Optional feature macro: KS_MAJORITY_EN
//   defined     : combiner = majority(ks5_bit, ks7_bit, ks9_bit)
//   not defined : Geffe combiner (ks7 selects between ks5 and ks9)
module keystream_cipher #(
    parameter int KS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [20:0] key,
    output logic        lfsr_reset,
    output logic [4:0]  seed5,
    output logic [6:0]  seed7,
    output logic [8:0]  seed9,
    input  logic        ks5_bit,
    input  logic        ks7_bit,
    input  logic        ks9_bit,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        running,
    output logic        key_err,
    output logic        ks_overflow
);

    localparam int PW = (KS_DEPTH > 1) ? $clog2(KS_DEPTH) : 1;
    localparam logic [PW:0] DEPTH_C = (PW+1)'(KS_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t      state_reg;
    logic [20:0] key_reg;
    logic        lfsr_reset_reg;
    logic        running_reg;
    logic        key_err_reg;
    logic        ks_overflow_reg;

    logic [7:0]  fifo_mem [KS_DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW:0] count_reg;

    logic [2:0]  pack_cnt_reg;
    logic [6:0]  pack_reg;

    logic        out_valid_reg;
    logic [7:0]  out_data_reg;

    logic        key_ok;
    logic        ks_bit;
    logic        sample;
    logic        push;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push_ok;
    logic        push_drop;
    logic [7:0]  pack_byte;

    // Each key segment seeds one LFSR; an all-zero seed would lock that LFSR.
    assign key_ok = (|key[4:0]) & (|key[11:5]) & (|key[20:12]);

    // Keystream combiner
`ifdef KS_MAJORITY_EN
    assign ks_bit = (ks5_bit & ks7_bit) | (ks5_bit & ks9_bit) | (ks7_bit & ks9_bit);
`else
    assign ks_bit = (ks7_bit & ks5_bit) ^ (~ks7_bit & ks9_bit);
`endif

    assign fifo_full  = (count_reg == DEPTH_C);
    assign fifo_empty = (count_reg == '0);

    // A start pulse flushes the datapath, so nothing is sampled on that edge.
    assign sample    = running_reg & ~start;
    assign push      = sample & (pack_cnt_reg == 3'd7);
    assign pack_byte = {ks_bit, pack_reg};

    assign in_ready  = running_reg & ~fifo_empty & (~out_valid_reg | out_ready);
    assign pop       = in_valid & in_ready;

    // A full FIFO still accepts a push when the head is popped on the same edge.
    assign push_ok   = push & (~fifo_full | pop);
    assign push_drop = push & fifo_full & ~pop;

    assign lfsr_reset  = lfsr_reset_reg;
    assign seed5       = key_reg[4:0];
    assign seed7       = key_reg[11:5];
    assign seed9       = key_reg[20:12];
    assign running     = running_reg;
    assign key_err     = key_err_reg;
    assign ks_overflow = ks_overflow_reg;
    assign out_valid   = out_valid_reg;
    assign out_data    = out_data_reg;

    // Control FSM: key latch, LFSR seeding handshake and sticky status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            key_reg         <= '0;
            lfsr_reset_reg  <= 1'b1;
            running_reg     <= 1'b0;
            key_err_reg     <= 1'b0;
            ks_overflow_reg <= 1'b0;
        end else if (start) begin
            key_reg        <= key;
            lfsr_reset_reg <= 1'b1;
            running_reg    <= 1'b0;
            if (key_ok) begin
                state_reg       <= ST_LOAD;
                key_err_reg     <= 1'b0;
                ks_overflow_reg <= 1'b0;
            end else begin
                state_reg   <= ST_IDLE;
                key_err_reg <= 1'b1;
            end
        end else begin
            case (state_reg)
                ST_LOAD: begin
                    // LFSRs load the seed on this edge; they free-run from now on.
                    state_reg      <= ST_RUN;
                    lfsr_reset_reg <= 1'b0;
                    running_reg    <= 1'b1;
                end
                ST_RUN: begin
                    state_reg <= ST_RUN;
                end
                default: begin
                    state_reg      <= ST_IDLE;
                    lfsr_reset_reg <= 1'b1;
                    running_reg    <= 1'b0;
                end
            endcase
            if (push_drop) begin
                ks_overflow_reg <= 1'b1;
            end
        end
    end

    // Bit packer: first sampled bit lands in bit 0 of the byte.
    always_ff @(posedge clk) begin
        if (reset || start) begin
            pack_cnt_reg <= '0;
            pack_reg     <= '0;
        end else if (sample) begin
            pack_cnt_reg <= pack_cnt_reg + 3'd1;
            pack_reg     <= {ks_bit, pack_reg[6:1]};
        end
    end

    // Keystream FIFO storage; no reset needed since pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok && !reset) begin
            fifo_mem[wr_ptr_reg] <= pack_byte;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset || start) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Output register: XOR accepted byte with FIFO head; hold while stalled.
    always_ff @(posedge clk) begin
        if (reset || start) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else if (pop) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= in_data ^ fifo_mem[rd_ptr_reg];
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keystream_cipher.sv
// Directed testbench for keystream_cipher with behavioural 5/7/9-bit LFSRs
// feeding the keystream inputs and a software keystream model for expectations.
module tb_keystream_cipher;

    localparam int KS_DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        start;
    logic [20:0] key;
    logic        lfsr_reset;
    logic [4:0]  seed5;
    logic [6:0]  seed7;
    logic [8:0]  seed9;
    logic        ks5_bit;
    logic        ks7_bit;
    logic        ks9_bit;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        running;
    logic        key_err;
    logic        ks_overflow;

    int errors = 0;
    int checks = 0;

    keystream_cipher #(.KS_DEPTH(KS_DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .key        (key),
        .lfsr_reset (lfsr_reset),
        .seed5      (seed5),
        .seed7      (seed7),
        .seed9      (seed9),
        .ks5_bit    (ks5_bit),
        .ks7_bit    (ks7_bit),
        .ks9_bit    (ks9_bit),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .running    (running),
        .key_err    (key_err),
        .ks_overflow(ks_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // LFSR step functions: right shift, feedback into the MSB
    function automatic logic [4:0] st5(input logic [4:0] s);
        return {s[0] ^ s[2], s[4:1]};
    endfunction
    function automatic logic [6:0] st7(input logic [6:0] s);
        return {s[0] ^ s[1], s[6:1]};
    endfunction
    function automatic logic [8:0] st9(input logic [8:0] s);
        return {s[0] ^ s[4], s[8:1]};
    endfunction

    function automatic logic comb(input logic a5, input logic a7, input logic a9);
`ifdef KS_MAJORITY_EN
        return (a5 & a7) | (a5 & a9) | (a7 & a9);
`else
        return a7 ? a5 : a9;
`endif
    endfunction

    // Behavioural LFSRs driven by the DUT's seed interface
    logic [4:0] l5;
    logic [6:0] l7;
    logic [8:0] l9;
    always @(posedge clk) begin
        l5 <= lfsr_reset ? seed5 : st5(l5);
        l7 <= lfsr_reset ? seed7 : st7(l7);
        l9 <= lfsr_reset ? seed9 : st9(l9);
    end
    assign ks5_bit = l5[0];
    assign ks7_bit = l7[0];
    assign ks9_bit = l9[0];

    // Keystream byte n after seeding with key k (bit 8n -> LSB)
    function automatic logic [7:0] model_byte(input logic [20:0] k, input int n);
        logic [4:0] a;
        logic [6:0] b;
        logic [8:0] c;
        logic [7:0] r;
        a = k[4:0];
        b = k[11:5];
        c = k[20:12];
        r = '0;
        for (int i = 0; i < 8 * n + 8; i++) begin
            if (i >= 8 * n) r[i - 8 * n] = comb(a[0], b[0], c[0]);
            a = st5(a);
            b = st7(b);
            c = st9(c);
        end
        return r;
    endfunction

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [20:0] k);
        start = 1'b1;
        key   = k;
        tick();
        start = 1'b0;
    endtask

    // Offer one byte, wait (bounded) for acceptance, return the result byte
    task automatic xfer(input string tag, input logic [7:0] din, output logic [7:0] dout);
        int n;
        n = 0;
        in_data   = din;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        check1({tag, "_in_ready_wait"}, in_ready, 1'b1);
        tick();
        check1({tag, "_latency_out_valid"}, out_valid, 1'b1);
        dout     = out_data;
        in_valid = 1'b0;
        $display("xfer %s: in=%02h out=%02h wait=%0d", tag, din, dout, n);
    endtask

    logic [20:0] k2, k3, k6;
    logic [7:0]  ct [16];
    logic [7:0]  d;
    logic [7:0]  held;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        key       = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        k2 = {9'h001, 7'h01, 5'h01};
        k3 = 21'h0A5A5A;
        k6 = {9'h1AB, 7'h33, 5'h0E};

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        check1("rst_lfsr_reset", lfsr_reset, 1'b1);
        check1("rst_running", running, 1'b0);
        check1("rst_in_ready", in_ready, 1'b0);
        check1("rst_out_valid", out_valid, 1'b0);
        check1("rst_key_err", key_err, 1'b0);
        check1("rst_ks_overflow", ks_overflow, 1'b0);
        $display("reset done");

        // 1: all-zero key is rejected
        do_start(21'h000000);
        check1("t1_key_err", key_err, 1'b1);
        check1("t1_running", running, 1'b0);
        tick();
        tick();
        check1("t1_lfsr_reset_held", lfsr_reset, 1'b1);
        check1("t1_running_held", running, 1'b0);
        $display("t1 zero key: key_err=%0b", key_err);

        // 2: keystream bytes for key {1,1,1}
        do_start(k2);
        check1("t2_key_err_cleared", key_err, 1'b0);
        check1("t2_lfsr_reset_load", lfsr_reset, 1'b1);
        tick();
        check1("t2_running", running, 1'b1);
        check1("t2_lfsr_reset_run", lfsr_reset, 1'b0);
        for (int i = 0; i < 16; i++) begin
            xfer("t2", 8'h00, d);
            check8("t2_ks_byte", d, model_byte(k2, i));
        end

        // 3: encrypt then decrypt with the same key
        do_start(k3);
        for (int i = 0; i < 16; i++) begin
            xfer("t3_enc", 8'(i), d);
            ct[i] = d;
            check8("t3_ct", d, 8'(i) ^ model_byte(k3, i));
        end
        do_start(k3);
        for (int i = 0; i < 16; i++) begin
            xfer("t3_dec", ct[i], d);
            check8("t3_pt", d, 8'(i));
        end

        // 5: output backpressure holds data, no loss or duplication
        do_start(k2);
        xfer("t5_b0", 8'h00, d);
        check8("t5_b0", d, model_byte(k2, 0));
        held      = d;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h3C;
        #1;
        for (int i = 0; i < 10; i++) begin
            check1("t5_in_ready_low", in_ready, 1'b0);
            tick();
            check1("t5_out_valid_held", out_valid, 1'b1);
            check8("t5_out_data_held", out_data, held);
        end
        $display("t5 stall released");
        xfer("t5_b1", 8'h3C, d);
        check8("t5_b1", d, 8'h3C ^ model_byte(k2, 1));
        xfer("t5_b2", 8'h00, d);
        check8("t5_b2", d, model_byte(k2, 2));
        xfer("t5_b3", 8'hFF, d);
        check8("t5_b3", d, 8'hFF ^ model_byte(k2, 3));

        // 4: keystream FIFO overflow
        do_start(k3);
        in_valid = 1'b0;
        repeat ((KS_DEPTH + 1) * 8) tick();
        check1("t4_no_overflow_yet", ks_overflow, 1'b0);
        repeat (2) tick();
        check1("t4_overflow", ks_overflow, 1'b1);
        for (int i = 0; i < KS_DEPTH; i++) begin
            xfer("t4", 8'h00, d);
            check8("t4_fifo_byte", d, model_byte(k3, i));
        end
        check1("t4_overflow_sticky", ks_overflow, 1'b1);

        // 6: restart mid-stream with a pending output byte
        out_ready = 1'b0;
        #1;
        check1("t6_pending_out_valid", out_valid, 1'b1);
        do_start(k6);
        check1("t6_out_valid_flushed", out_valid, 1'b0);
        check1("t6_in_ready_empty", in_ready, 1'b0);
        check1("t6_ks_overflow_cleared", ks_overflow, 1'b0);
        check1("t6_key_err", key_err, 1'b0);
        xfer("t6", 8'h5A, d);
        check8("t6_first_byte", d, 8'h5A ^ model_byte(k6, 0));

        // Reset mid-operation
        repeat (20) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check1("midrst_running", running, 1'b0);
        check1("midrst_lfsr_reset", lfsr_reset, 1'b1);
        check1("midrst_out_valid", out_valid, 1'b0);
        check1("midrst_in_ready", in_ready, 1'b0);
        $display("mid-operation reset done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
